mux_sel_scheduler: RTL

Sequences the 3-bit channel select that drives the mux/demux datapath, replacing a bare free-running select counter. It rotates round-robin over a software-visible enable mask and holds each channel for a programmable dwell period. It supports run/stop and single-step control, and flags each completed pass over the enabled set. It sits between the board controls (switches/buttons) and the mux and demux select inputs.

---
 rtl/mux_sched_pkg.sv | 15 +
 rtl/mux_sel_scheduler_rr_next_sel.sv | 34 +++
 rtl/mux_sel_scheduler.sv | 84 ++++++++
 3 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and sizes for the channel-select scheduler.
// No logic; no latency; no backpressure.
// Imported by mux_sel_scheduler and rr_next_sel.
package mux_sched_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mux_sel_scheduler_rr_next_sel.sv
// Round-robin finder: next enabled channel after cur, wrapping back to cur.
// Purely combinational, zero latency.
// No backpressure; none flags an all-zero mask.
module rr_next_sel
  import mux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wraps,
  output logic              none
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Search cur+1 .. cur+8; the last candidate is cur itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && ch_en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wraps = (nxt <= cur);
  assign none  = ~|ch_en;

endmodule

// File: rtl/mux_sel_scheduler.sv
// Mux/demux channel-select scheduler: round-robin over ch_en, DWELL-cycle hold, run/step control.
// Latency: sel/wrap/valid update one edge after the trigger (terminal count, step, mask miss).
// No backpressure; step support is compiled in only with MUXSCHED_STEP_EN defined.
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int DWELL = 33554432,
  parameter int CNT_W = 28
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              run,
  input  logic              step,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              wrap
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DWELL - 1);

  sched_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] nxt;
  logic [SEL_W-1:0] sel_d;
  logic             wraps;
  logic             none;
  logic             forced;
  logic             tc;
  logic             step_adv;
  logic             adv;

  rr_next_sel u_rr (
    .ch_en (ch_en),
    .cur   (sel),
    .nxt   (nxt),
    .wraps (wraps),
    .none  (none)
  );

`ifdef MUXSCHED_STEP_EN
  assign step_adv = !run && step;
`else
  assign step_adv = 1'b0 & step;
`endif

  // A mask miss on the current channel outranks dwell expiry and step.
  assign forced = !ch_en[sel];
  assign tc     = (state == RUN) && run && (cnt == TC);
  assign adv    = forced || tc || step_adv;
  assign sel_d  = adv ? nxt : sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (none) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (state == IDLE) begin
      state <= run ? RUN : HOLD;
      cnt   <= '0;
      valid <= ch_en[sel];
      wrap  <= 1'b0;
    end else begin
      state <= run ? RUN : HOLD;
      sel   <= sel_d;
      wrap  <= adv && wraps;
      valid <= ch_en[sel_d];
      // HOLD keeps the counter at zero so a resumed RUN starts a full dwell.
      if (forced || !run || state == HOLD || cnt == TC)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule
